acq_ram_writer: RTL and testbench
=================================

// Module: acq_ram_writer
// PURPOSE
//  Downstream of the disc reader. Consumes its timing words (DATA/WRITE strobe) and writes them
//  sequentially into external acquisition SRAM through a small elastic FIFO and a fixed 3-cycle
//  SRAM write sequencer. Owns the acquisition RUN enable fed back to the reader. Stops on
//  ABORT, N index marks, or memory full. Reports address, overrun and status to host registers.
// PARAMETERS
//  BITS        8   word width; MSB = index mark, (2^(BITS-1))-1 with MSB clear = overflow word
//  ADDR_BITS   19  SRAM address width; capacity = 2^ADDR_BITS words
//  FIFO_DEPTH  4   elastic buffer depth in words, power of two, >=2
//  IDX_BITS    4   width of index stop count
// PORTS
//  CLOCK       in   1          master clock; all logic on posedge
//  RESET       in   1          asynchronous, active-high; clears all state
//  START       in   1          1-cycle pulse: begin acquisition at address 0 (ignored unless IDLE/DONE)
//  ABORT       in   1          1-cycle pulse: stop immediately, discard buffered words
//  IDX_STOP    in   IDX_BITS   index marks to capture before stop; 0 = no index stop
//  WR_DATA     in   BITS       word from disc reader
//  WR_STROBE   in   1          1-cycle valid for WR_DATA
//  RUN         out  1          acquisition enable to disc reader
//  SRAM_A      out  ADDR_BITS  SRAM address
//  SRAM_D      out  BITS       SRAM write data
//  SRAM_DRV    out  1          1 = drive SRAM data bus
//  SRAM_WE_N   out  1          SRAM write enable, active low
//  BUSY        out  1          state != IDLE and != DONE
//  DONE        out  1          acquisition finished, all accepted words written
//  MEM_FULL    out  1          sticky: capacity reached
//  OVERRUN     out  1          sticky: word dropped on FIFO full
//  ADDR_OUT    out  ADDR_BITS+1 words written so far
// BEHAVIOUR
//  Reset: RUN=0, SRAM_A=0, SRAM_D=0, SRAM_DRV=0, SRAM_WE_N=1, BUSY=0, DONE=0, MEM_FULL=0,
//   OVERRUN=0, ADDR_OUT=0, FIFO empty, main FSM IDLE, write FSM W_IDLE. Async reset mid-write
//   forces SRAM_WE_N=1, SRAM_DRV=0 immediately.
//  Main FSM: IDLE -START-> ACQ; ACQ -stop cond-> DRAIN; DRAIN -FIFO empty & W_IDLE-> DONE;
//   DONE -START-> ACQ; ACQ/DRAIN -ABORT-> DRAIN with FIFO flushed (in-flight write completes).
//   START clears MEM_FULL, OVERRUN, ADDR_OUT, accept counter, index counter, DONE.
//  RUN = (state==ACQ), registered; falls the cycle after the stop condition is detected.
//  Accept: WR_STROBE while ACQ pushes WR_DATA; strobes in any other state are ignored.
//   FIFO full on strobe -> word dropped, OVERRUN=1 (sticky).
//  Accept counter (ADDR_BITS+1 wide) counts pushed words; reaching 2^ADDR_BITS -> MEM_FULL=1,
//   stop; further strobes dropped without setting OVERRUN.
//  Index counting: a word with MSB=1 whose previously accepted word had MSB=0 (or is the first
//   word) is one index mark; consecutive MSB=1 words count once. Counter saturates.
//   IDX_STOP!=0 and count reaches IDX_STOP -> stop; the marking word itself is written.
//  Simultaneous stop causes in one cycle: all recorded (MEM_FULL set if applicable); ABORT wins
//   over START.
//  Write FSM: W_IDLE -FIFO nonempty-> W_SETUP (pop; SRAM_A=ADDR_OUT, SRAM_D=word, DRV=1)
//   -> W_STROBE (WE_N=0, exactly 1 cycle) -> W_HOLD (WE_N=1, DRV=1, ADDR_OUT+1) -> W_IDLE.
//   Address/data stable from W_SETUP through W_HOLD. Sustained rate: 1 word / 4 cycles;
//   FIFO absorbs bursts. Latency strobe->WE_N low: 3 cycles when idle.
//  Address does not wrap; SRAM_A never exceeds 2^ADDR_BITS-1.
// STRUCTURE
//  Shared package/header: main FSM state codes (IDLE, ACQ, DRAIN, DONE), write FSM codes
//   (W_IDLE, W_SETUP, W_STROBE, W_HOLD), overflow word constant.
//  Sub-module: acq_sync_fifo (BITS wide, FIFO_DEPTH deep, push/pop/flush, full/empty flags).
//  Top: main FSM, accept/index counters, write sequencer.
// TESTING
//  1 Reset: assert RESET mid-W_STROBE -> WE_N=1, DRV=0 same cycle; all outputs at reset values.
//  2 START, IDX_STOP=1, words 0x10,0x20,0x30,0x40,0x85 every 6 cycles -> SRAM writes
//    A=0..4 same data, WE_N low 1 cycle each, RUN falls after 0x85, DONE=1, ADDR_OUT=5.
//  3 IDX_STOP=2, stream 0x05,0x83,0x84,0x10,0x81 -> first index = 0x83/0x84 pair, stop after 0x81,
//    ADDR_OUT=5.
//  4 ADDR_BITS=4, IDX_STOP=0, 20 words every 6 cycles -> 16 written, MEM_FULL=1, OVERRUN=0, DONE.
//  5 FIFO_DEPTH=4, 10 back-to-back strobes 0x01..0x0A -> OVERRUN=1; SRAM sequence is a
//    strictly increasing subsequence starting 0x01, no duplicates, ADDR_OUT = words accepted.
//  6 ABORT with 3 words buffered during W_STROBE -> current write completes, rest discarded,
//    DONE next idle cycle, ADDR_OUT = prior count + 1.

Source files
------------

// File: rtl/acq_ram_writer_pkg.sv
// Shared definitions for the acquisition RAM writer: FSM state codes and word constants.
package acq_ram_writer_pkg;

    typedef enum logic [1:0] {
        M_IDLE,
        M_ACQ,
        M_DRAIN,
        M_DONE
    } main_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SETUP,
        W_STROBE,
        W_HOLD
    } wr_state_t;

    // Overflow marker emitted by the disc reader for the default 8-bit word.
    localparam logic [7:0] OVERFLOW_WORD = 8'h7F;

endpackage

// File: rtl/acq_sync_fifo.sv
// Small synchronous elastic FIFO with push/pop/flush and full/empty flags.
module acq_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge CLOCK) begin
        if (push && !full && !flush)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/acq_ram_writer.sv
// Buffers disc-reader timing words and writes them sequentially into acquisition SRAM,
// owning the RUN enable and stopping on abort, index-mark count or memory full.
module acq_ram_writer
    import acq_ram_writer_pkg::*;
#(
    parameter int BITS       = 8,
    parameter int ADDR_BITS  = 19,
    parameter int FIFO_DEPTH = 4,
    parameter int IDX_BITS   = 4
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [IDX_BITS-1:0]  IDX_STOP,
    input  logic [BITS-1:0]      WR_DATA,
    input  logic                 WR_STROBE,
    output logic                 RUN,
    output logic [ADDR_BITS-1:0] SRAM_A,
    output logic [BITS-1:0]      SRAM_D,
    output logic                 SRAM_DRV,
    output logic                 SRAM_WE_N,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 MEM_FULL,
    output logic                 OVERRUN,
    output logic [ADDR_BITS:0]   ADDR_OUT
);
    localparam logic [ADDR_BITS:0] CAPACITY = {1'b1, {ADDR_BITS{1'b0}}};

    main_state_t m_state;
    wr_state_t   w_state;

    logic [ADDR_BITS:0] acc_cnt;
    logic [ADDR_BITS:0] acc_next;
    logic [IDX_BITS-1:0] idx_cnt;
    logic [IDX_BITS-1:0] idx_next;
    logic prev_msb;

    logic start_go, abort_go, strobe_acq, push, drop, is_mark, hit_full, hit_idx, stop;
    logic fifo_pop, fifo_full, fifo_empty;
    logic [BITS-1:0] fifo_data;

    // ABORT outranks START; START only takes effect from IDLE or DONE.
    assign start_go   = START && !ABORT && (m_state == M_IDLE || m_state == M_DONE);
    assign abort_go   = ABORT && (m_state == M_ACQ || m_state == M_DRAIN);
    assign strobe_acq = WR_STROBE && (m_state == M_ACQ) && !ABORT && !MEM_FULL;
    assign push       = strobe_acq && !fifo_full;
    assign drop       = strobe_acq && fifo_full;
    assign acc_next   = acc_cnt + 1'b1;
    assign is_mark    = push && WR_DATA[BITS-1] && !prev_msb;
    assign idx_next   = (idx_cnt == '1) ? idx_cnt : idx_cnt + 1'b1;
    assign hit_full   = push && (acc_next == CAPACITY);
    assign hit_idx    = is_mark && (IDX_STOP != '0) && (idx_next >= IDX_STOP);
    assign stop       = hit_full || hit_idx;
    assign fifo_pop   = (w_state == W_IDLE) && !fifo_empty && !abort_go;

    acq_sync_fifo #(
        .WIDTH (BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .push      (push),
        .push_data (WR_DATA),
        .pop       (fifo_pop),
        .flush     (abort_go),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // NOTE: all state uses non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            m_state  <= M_IDLE;
            RUN      <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            MEM_FULL <= 1'b0;
            OVERRUN  <= 1'b0;
            acc_cnt  <= '0;
            idx_cnt  <= '0;
            prev_msb <= 1'b0;
        end else begin
            unique case (m_state)
                M_IDLE, M_DONE: begin
                    if (start_go) begin
                        m_state  <= M_ACQ;
                        RUN      <= 1'b1;
                        BUSY     <= 1'b1;
                        DONE     <= 1'b0;
                        MEM_FULL <= 1'b0;
                        OVERRUN  <= 1'b0;
                        acc_cnt  <= '0;
                        idx_cnt  <= '0;
                        prev_msb <= 1'b0;
                    end
                end
                M_ACQ: begin
                    if (push) begin
                        acc_cnt  <= acc_next;
                        prev_msb <= WR_DATA[BITS-1];
                    end
                    if (is_mark)
                        idx_cnt <= idx_next;
                    if (hit_full)
                        MEM_FULL <= 1'b1;
                    if (drop)
                        OVERRUN <= 1'b1;
                    if (ABORT || stop) begin
                        m_state <= M_DRAIN;
                        RUN     <= 1'b0;
                    end
                end
                M_DRAIN: begin
                    if (!ABORT && fifo_empty && w_state == W_IDLE) begin
                        m_state <= M_DONE;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                    end
                end
                default: m_state <= M_IDLE;
            endcase
        end
    end

    // Fixed four-phase write: address/data set up, one WE_N low cycle, hold, idle.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            w_state   <= W_IDLE;
            SRAM_A    <= '0;
            SRAM_D    <= '0;
            SRAM_DRV  <= 1'b0;
            SRAM_WE_N <= 1'b1;
            ADDR_OUT  <= '0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (start_go)
                        ADDR_OUT <= '0;
                    if (fifo_pop) begin
                        w_state  <= W_SETUP;
                        SRAM_A   <= ADDR_OUT[ADDR_BITS-1:0];
                        SRAM_D   <= fifo_data;
                        SRAM_DRV <= 1'b1;
                    end
                end
                W_SETUP: begin
                    w_state   <= W_STROBE;
                    SRAM_WE_N <= 1'b0;
                end
                W_STROBE: begin
                    w_state   <= W_HOLD;
                    SRAM_WE_N <= 1'b1;
                    ADDR_OUT  <= ADDR_OUT + 1'b1;
                end
                W_HOLD: begin
                    w_state  <= W_IDLE;
                    SRAM_DRV <= 1'b0;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acq_ram_writer.sv
// Scoreboard bench: stimulus queues expected SRAM writes, a negedge monitor checks each WE_N pulse.
module tb_acq_ram_writer;
    import acq_ram_writer_pkg::*;

    localparam int BITS      = 8;
    localparam int ADDR_BITS = 4;
    localparam int IDX_BITS  = 4;

    logic                 CLOCK = 1'b0;
    logic                 RESET = 1'b1;
    logic                 START = 1'b0;
    logic                 ABORT = 1'b0;
    logic [IDX_BITS-1:0]  IDX_STOP = '0;
    logic [BITS-1:0]      WR_DATA = '0;
    logic                 WR_STROBE = 1'b0;
    logic                 RUN;
    logic [ADDR_BITS-1:0] SRAM_A;
    logic [BITS-1:0]      SRAM_D;
    logic                 SRAM_DRV;
    logic                 SRAM_WE_N;
    logic                 BUSY;
    logic                 DONE;
    logic                 MEM_FULL;
    logic                 OVERRUN;
    logic [ADDR_BITS:0]   ADDR_OUT;

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [BITS-1:0]      data;
    } wr_t;

    wr_t                exp_q[$];
    wr_t                mon_e;
    logic [ADDR_BITS:0] exp_addr = '0;
    bit                 prev_we_low = 1'b0;
    int                 checks = 0;
    int                 errors = 0;

    acq_ram_writer #(
        .BITS       (BITS),
        .ADDR_BITS  (ADDR_BITS),
        .FIFO_DEPTH (4),
        .IDX_BITS   (IDX_BITS)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .START     (START),
        .ABORT     (ABORT),
        .IDX_STOP  (IDX_STOP),
        .WR_DATA   (WR_DATA),
        .WR_STROBE (WR_STROBE),
        .RUN       (RUN),
        .SRAM_A    (SRAM_A),
        .SRAM_D    (SRAM_D),
        .SRAM_DRV  (SRAM_DRV),
        .SRAM_WE_N (SRAM_WE_N),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .MEM_FULL  (MEM_FULL),
        .OVERRUN   (OVERRUN),
        .ADDR_OUT  (ADDR_OUT)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Every WE_N low cycle must match the oldest outstanding expected write.
    always @(negedge CLOCK) begin
        if (!RESET && SRAM_WE_N == 1'b0) begin
            check("we_pulse_width", 32'(prev_we_low), 0);
            check("drv_during_we", 32'(SRAM_DRV), 1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got A=0x%0h D=0x%0h expected no write", SRAM_A, SRAM_D);
            end else begin
                mon_e = exp_q.pop_front();
                check("sram_addr", 32'(SRAM_A), 32'(mon_e.addr));
                check("sram_data", 32'(SRAM_D), 32'(mon_e.data));
            end
        end
        prev_we_low = !RESET && !SRAM_WE_N;
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_start(input logic [IDX_BITS-1:0] idx);
        IDX_STOP = idx;
        START    = 1'b1;
        exp_addr = '0;
        tick();
        START = 1'b0;
    endtask

    task automatic send(input logic [BITS-1:0] d, input bit accepted);
        WR_DATA   = d;
        WR_STROBE = 1'b1;
        if (accepted) begin
            exp_q.push_back('{addr: exp_addr[ADDR_BITS-1:0], data: d});
            exp_addr++;
        end
        tick();
        WR_STROBE = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int n = 0;
        while (!DONE && n < bound) begin
            tick();
            n++;
        end
        check({name, "_done"}, 32'(DONE), 1);
        check({name, "_busy"}, 32'(BUSY), 0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_run"},      32'(RUN), 0);
        check({name, "_sram_a"},   32'(SRAM_A), 0);
        check({name, "_sram_d"},   32'(SRAM_D), 0);
        check({name, "_drv"},      32'(SRAM_DRV), 0);
        check({name, "_we_n"},     32'(SRAM_WE_N), 1);
        check({name, "_busy"},     32'(BUSY), 0);
        check({name, "_done"},     32'(DONE), 0);
        check({name, "_mem_full"}, 32'(MEM_FULL), 0);
        check({name, "_overrun"},  32'(OVERRUN), 0);
        check({name, "_addr_out"}, 32'(ADDR_OUT), 0);
    endtask

    logic [BITS-1:0] t2_words [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h85};
    logic [BITS-1:0] t3_words [5] = '{8'h05, 8'h83, 8'h84, 8'h10, 8'h81};

    initial begin
        bit found;

        idle(2);
        check_reset_values("por");
        RESET = 1'b0;
        tick();

        // Reset asserted while WE_N is low must release the bus at once.
        do_start('0);
        send(8'h55, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge CLOCK);
            if (!SRAM_WE_N)
                found = 1'b1;
        end
        check("t1_we_low_seen", 32'(found), 1);
        #1 RESET = 1'b1;
        #1;
        check("t1_async_we_n", 32'(SRAM_WE_N), 1);
        check("t1_async_drv", 32'(SRAM_DRV), 0);
        check_reset_values("t1");
        tick();
        RESET = 1'b0;
        tick();

        // One index mark stops the run; the mark itself is written.
        do_start(4'd1);
        check("t2_run_high", 32'(RUN), 1);
        check("t2_busy_high", 32'(BUSY), 1);
        for (int i = 0; i < 5; i++) begin
            send(t2_words[i], 1'b1);
            if (i == 3)
                check("t2_run_before_mark", 32'(RUN), 1);
            if (i == 4)
                check("t2_run_after_mark", 32'(RUN), 0);
            idle(5);
        end
        wait_done("t2", 30);
        check("t2_addr_out", 32'(ADDR_OUT), 5);
        check("t2_mem_full", 32'(MEM_FULL), 0);
        check("t2_overrun", 32'(OVERRUN), 0);

        // Consecutive MSB words count as one mark; strobes after stop are ignored.
        do_start(4'd2);
        for (int i = 0; i < 5; i++) begin
            send(t3_words[i], 1'b1);
            if (i == 2)
                check("t3_run_after_pair", 32'(RUN), 1);
            if (i == 4)
                check("t3_run_after_second", 32'(RUN), 0);
            idle(5);
        end
        send(8'h99, 1'b0);
        wait_done("t3", 30);
        check("t3_addr_out", 32'(ADDR_OUT), 5);

        // Capacity of 16 words: the rest are dropped silently.
        do_start('0);
        for (int i = 0; i < 20; i++) begin
            send((i == 7) ? OVERFLOW_WORD : 8'(8'h20 + i), i < 16);
            if (i == 15) begin
                check("t4_mem_full_set", 32'(MEM_FULL), 1);
                check("t4_run_low", 32'(RUN), 0);
            end
            idle(5);
        end
        wait_done("t4", 30);
        check("t4_addr_out", 32'(ADDR_OUT), 16);
        check("t4_mem_full", 32'(MEM_FULL), 1);
        check("t4_overrun", 32'(OVERRUN), 0);

        // Back-to-back burst overflows the 4-deep buffer: 0x06, 0x08..0x0A are lost.
        do_start('0);
        for (int i = 1; i <= 10; i++) begin
            WR_DATA   = 8'(i);
            WR_STROBE = 1'b1;
            if (i <= 5 || i == 7) begin
                exp_q.push_back('{addr: exp_addr[ADDR_BITS-1:0], data: 8'(i)});
                exp_addr++;
            end
            tick();
        end
        WR_STROBE = 1'b0;
        idle(30);
        check("t5_overrun", 32'(OVERRUN), 1);
        check("t5_run_still_high", 32'(RUN), 1);
        check("t5_addr_out", 32'(ADDR_OUT), 6);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        wait_done("t5", 10);
        check("t5_addr_out_final", 32'(ADDR_OUT), 6);

        // Abort during the second write's strobe with three words still buffered.
        do_start('0);
        for (int i = 0; i < 5; i++) begin
            WR_DATA   = 8'(8'h61 + i);
            WR_STROBE = 1'b1;
            if (i < 2) begin
                exp_q.push_back('{addr: exp_addr[ADDR_BITS-1:0], data: 8'(8'h61 + i)});
                exp_addr++;
            end
            tick();
        end
        WR_STROBE = 1'b0;
        idle(2);
        check("t6_in_strobe", 32'(SRAM_WE_N), 0);
        check("t6_addr_before_abort", 32'(ADDR_OUT), 1);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check("t6_run_low", 32'(RUN), 0);
        check("t6_not_done_yet", 32'(DONE), 0);
        wait_done("t6", 5);
        check("t6_addr_out", 32'(ADDR_OUT), 2);
        idle(6);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
